// File: rtl/fetch_unit_pkg.sv
// Shared RV32 core definitions: instruction field positions, opcode classes and
// the fetch buffer entry layout. The fetch unit and the decoder both use it.
package fetch_unit_pkg;

  localparam int OP_LSB = 0;
  localparam int OP_MSB = 6;
  localparam int RD_LSB = 7;
  localparam int RD_MSB = 11;
  localparam int F3_LSB = 12;
  localparam int F3_MSB = 14;
  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;
  localparam int F7_LSB = 25;
  localparam int F7_MSB = 31;

  // Instructions in flight (outstanding + buffered) never exceed this.
  localparam logic [2:0] MAX_INFLIGHT = 3'd2;

  typedef enum logic [6:0] {
    TYPE_R      = 7'h33,
    TYPE_I_ALU  = 7'h13,
    TYPE_I_LOAD = 7'h03,
    TYPE_S      = 7'h23,
    TYPE_B      = 7'h63,
    TYPE_J      = 7'h6F
  } opcode_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry in-order buffer of {pc, instr}. Flush empties it; push and pop may
// coincide, and a push into a full buffer is taken when the head pops that cycle.
module fetch_fifo #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_empty,
  output logic [1:0]   o_count
);

  logic [1:0][W-1:0] r_mem;
  logic              r_wptr, r_rptr;
  logic [1:0]        r_count;
  logic              w_pop, w_push;

  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem   <= '0;
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else if (i_flush) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_empty = (r_count == 2'd0);
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues word-aligned requests, buffers in-order responses with
// their PC, and on redirect flushes the buffer and discards responses still owed.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [31:0] dec_instr,
  output logic [31:0] dec_pc,
  output logic [6:0]  dec_op,
  output logic [2:0]  dec_funct3,
  output logic [6:0]  dec_funct7
);

  logic         r_run;
  logic [31:0]  r_pc, r_rsp_pc;
  logic [1:0]   r_outst, r_discard;
  logic         w_fire, w_rsp, w_push, w_pop, w_empty;
  logic [1:0]   w_cnt, w_outst_nxt;
  fetch_entry_t w_wdata, w_head;

  assign w_fire      = imem_req_valid && imem_req_ready;
  // A response with nothing outstanding is not ours (e.g. left over from before reset).
  assign w_rsp       = imem_rsp_valid && (r_outst != 2'd0);
  assign w_push      = w_rsp && (r_discard == 2'd0) && !redirect_valid;
  assign w_pop       = dec_valid && dec_ready && !redirect_valid;
  assign w_outst_nxt = r_outst + {1'b0, w_fire} - {1'b0, w_rsp};

  assign imem_req_valid = r_run && (({1'b0, r_outst} + {1'b0, w_cnt}) < MAX_INFLIGHT);
  assign imem_req_addr  = r_pc;

  // Responses return in order, so the PC of the next kept response is tracked
  // sequentially from the last redirect rather than stored per request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run     <= 1'b0;
      r_pc      <= align_pc(RESET_PC);
      r_rsp_pc  <= align_pc(RESET_PC);
      r_outst   <= 2'd0;
      r_discard <= 2'd0;
    end else begin
      r_run   <= 1'b1;
      r_outst <= w_outst_nxt;
      if (redirect_valid) begin
        r_pc      <= align_pc(redirect_pc);
        r_rsp_pc  <= align_pc(redirect_pc);
        r_discard <= w_outst_nxt;
      end else begin
        if (w_fire) r_pc <= r_pc + 32'd4;
        if (w_rsp && (r_discard != 2'd0)) r_discard <= r_discard - 2'd1;
        if (w_push) r_rsp_pc <= r_rsp_pc + 32'd4;
      end
    end
  end

  assign w_wdata.pc    = r_rsp_pc;
  assign w_wdata.instr = imem_rsp_data;

  fetch_fifo #(.W(64)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_data  (w_wdata),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_count (w_cnt)
  );

  assign dec_valid  = !w_empty;
  assign dec_instr  = w_head.instr;
  assign dec_pc     = w_head.pc;
  assign dec_op     = dec_instr[OP_MSB:OP_LSB];
  assign dec_funct3 = dec_instr[F3_MSB:F3_LSB];
  assign dec_funct7 = dec_instr[F7_MSB:F7_LSB];

endmodule
